// File: rtl/wash_pkg.sv
// Shared definitions for the wash supervisor: mode codes, fault codes,
// tracker states, default phase lengths and the actuator bundle.
package wash_pkg;

  localparam logic [2:0] MODE_STBY  = 3'd0;
  localparam logic [2:0] MODE_FILL  = 3'd1;
  localparam logic [2:0] MODE_RINSE = 3'd2;
  localparam logic [2:0] MODE_WASH  = 3'd3;
  localparam logic [2:0] MODE_SPIN  = 3'd4;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_CODE  = 2'b01;
  localparam logic [1:0] ERR_TRANS = 2'b10;
  localparam logic [1:0] ERR_DUR   = 2'b11;

  localparam int DEF_FILL_LEN  = 4;
  localparam int DEF_RINSE_LEN = 6;
  localparam int DEF_WASH_LEN  = 11;
  localparam int DEF_SPIN_LEN  = 9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FAULT
  } trk_state_e;

  typedef struct packed {
    logic valve;
    logic drain;
    logic slow;
    logic fast;
  } act_t;

endpackage

// File: rtl/wash_act_decode.sv
// Combinational phase-code to actuator decode; illegal codes and standby
// leave every actuator off.
module wash_act_decode
  import wash_pkg::*;
(
  input  logic [2:0] mode_i,
  output act_t       act_o
);

  always_comb begin
    act_o = '0;
    case (mode_i)
      MODE_FILL:  act_o.valve = 1'b1;
      MODE_RINSE: begin
        act_o.valve = 1'b1;
        act_o.slow  = 1'b1;
      end
      MODE_WASH:  act_o.slow  = 1'b1;
      MODE_SPIN:  begin
        act_o.drain = 1'b1;
        act_o.fast  = 1'b1;
      end
      default:    act_o = '0;
    endcase
  end

endmodule

// File: rtl/wash_supervisor.sv
// Wash-cycle supervisor: registered actuator drive plus a sequence tracker
// that faults on illegal codes/transitions. Define WASH_SUP_DURATION_CHK_EN
// to also enforce exact phase durations.
module wash_supervisor
  import wash_pkg::*;
#(
  parameter int FILL_LEN  = DEF_FILL_LEN,
  parameter int RINSE_LEN = DEF_RINSE_LEN,
  parameter int WASH_LEN  = DEF_WASH_LEN,
  parameter int SPIN_LEN  = DEF_SPIN_LEN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] mode,
  output logic       valve_on,
  output logic       drain_on,
  output logic       motor_slow,
  output logic       motor_fast,
  output logic       busy,
  output logic       done,
  output logic       abort,
  output logic       err,
  output logic [1:0] err_code,
  output logic [7:0] cycles
);

  logic [2:0] mode_q;
  logic [3:0] cnt_q;
  trk_state_e state_q;

  act_t       act_d;
  logic       same_d, step_d, fault_d, done_d, abort_d;
  logic [1:0] code_d;

  wash_act_decode u_dec (
    .mode_i (mode),
    .act_o  (act_d)
  );

`ifdef WASH_SUP_DURATION_CHK_EN
  logic [4:0] held_d;
  logic [4:0] len_d;

  function automatic logic [4:0] phase_len(input logic [2:0] m);
    case (m)
      MODE_FILL:  return 5'(FILL_LEN);
      MODE_RINSE: return 5'(RINSE_LEN);
      MODE_WASH:  return 5'(WASH_LEN);
      MODE_SPIN:  return 5'(SPIN_LEN);
      default:    return 5'd0;
    endcase
  endfunction

  // cnt_q clears on entry, so cycles spent in the previous phase is cnt_q+1
  assign held_d = {1'b0, cnt_q} + 5'd1;
  assign len_d  = phase_len(mode_q);
`endif

  always_comb begin
    same_d  = (mode == mode_q);
    step_d  = (mode_q == MODE_STBY) ? (mode == MODE_FILL)
                                    : ((mode_q < MODE_SPIN) && (mode == mode_q + 3'd1));
    fault_d = 1'b0;
    code_d  = ERR_NONE;
    done_d  = 1'b0;
    abort_d = 1'b0;
    if (mode > MODE_SPIN) begin
      fault_d = 1'b1;
      code_d  = ERR_CODE;
    end else if (same_d) begin
`ifdef WASH_SUP_DURATION_CHK_EN
      if (len_d != 5'd0 && held_d == len_d) begin
        fault_d = 1'b1;
        code_d  = ERR_DUR;
      end
`endif
    end else if (mode == MODE_STBY) begin
      if (mode_q == MODE_SPIN) begin
        done_d = 1'b1;
`ifdef WASH_SUP_DURATION_CHK_EN
        if (held_d != len_d) begin
          done_d  = 1'b0;
          abort_d = 1'b1;
        end
`endif
      end else begin
        abort_d = 1'b1;
      end
    end else if (step_d) begin
`ifdef WASH_SUP_DURATION_CHK_EN
      if (len_d != 5'd0 && held_d != len_d) begin
        fault_d = 1'b1;
        code_d  = ERR_DUR;
      end
`endif
    end else begin
      fault_d = 1'b1;
      code_d  = ERR_TRANS;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= MODE_STBY;
      cnt_q      <= 4'd0;
      state_q    <= ST_IDLE;
      valve_on   <= 1'b0;
      drain_on   <= 1'b0;
      motor_slow <= 1'b0;
      motor_fast <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      abort      <= 1'b0;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
      cycles     <= 8'd0;
    end else begin
      mode_q <= mode;
      cnt_q  <= !same_d ? 4'd0 : (cnt_q == 4'hF) ? 4'hF : cnt_q + 4'd1;
      if (state_q == ST_FAULT || fault_d) begin
        // Fault is terminal until reset; the first recorded code is kept
        if (state_q != ST_FAULT) begin
          err      <= 1'b1;
          err_code <= code_d;
        end
        state_q    <= ST_FAULT;
        valve_on   <= 1'b0;
        drain_on   <= 1'b0;
        motor_slow <= 1'b0;
        motor_fast <= 1'b0;
        busy       <= 1'b0;
        done       <= 1'b0;
        abort      <= 1'b0;
      end else begin
        state_q    <= (mode == MODE_STBY) ? ST_IDLE : ST_RUN;
        valve_on   <= act_d.valve;
        drain_on   <= act_d.drain;
        motor_slow <= act_d.slow;
        motor_fast <= act_d.fast;
        busy       <= (mode != MODE_STBY);
        done       <= done_d;
        abort      <= abort_d;
        if (done_d && cycles != 8'hFF)
          cycles <= cycles + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_wash_supervisor.sv
// Self-checking bench for wash_supervisor: directed scenarios plus a random
// phase walk, all compared cycle by cycle against a behavioural model.
module tb_wash_supervisor;

  localparam int FL = 4;
  localparam int RL = 6;
  localparam int WL = 11;
  localparam int SL = 9;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] mode;
  logic       valve_on, drain_on, motor_slow, motor_fast;
  logic       busy, done, abort, err;
  logic [1:0] err_code;
  logic [7:0] cycles;

  always #5 clk = ~clk;

  wash_supervisor #(
    .FILL_LEN  (FL),
    .RINSE_LEN (RL),
    .WASH_LEN  (WL),
    .SPIN_LEN  (SL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .valve_on   (valve_on),
    .drain_on   (drain_on),
    .motor_slow (motor_slow),
    .motor_fast (motor_fast),
    .busy       (busy),
    .done       (done),
    .abort      (abort),
    .err        (err),
    .err_code   (err_code),
    .cycles     (cycles)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int done_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase rules expressed with tables and a plain run-length count
  int         len_tab [5] = '{0, FL, RL, WL, SL};
  int         nxt_tab [5] = '{1, 2, 3, 4, 0};
  logic [3:0] act_tab [8] = '{4'b0000, 4'b1000, 4'b1010, 4'b0010, 4'b0101, 4'b0000, 4'b0000, 4'b0000};
  bit         dur_en;
  int         m_prev, m_run, m_cycles;
  bit         m_fault, e_done, e_abort, e_busy;
  logic [1:0] m_code;
  logic [3:0] e_act;

  function automatic void model_reset();
    m_prev = 0; m_run = 1; m_cycles = 0;
    m_fault = 0; m_code = 2'b00;
    e_done = 0; e_abort = 0; e_busy = 0; e_act = 4'b0000;
  endfunction

  function automatic void model_step(input int cur);
    bit         bad;
    logic [1:0] code;
    bad = 0; code = 2'b00; e_done = 0; e_abort = 0;
    if (!m_fault) begin
      if (cur > 4) begin
        bad = 1; code = 2'b01;
      end else if (cur == m_prev) begin
        if (dur_en && m_prev != 0 && m_run == len_tab[m_prev]) begin
          bad = 1; code = 2'b11;
        end
      end else if (cur == 0) begin
        if (m_prev == 4 && (!dur_en || m_run == len_tab[4])) e_done = 1;
        else e_abort = 1;
      end else if (cur == nxt_tab[m_prev]) begin
        if (dur_en && m_prev != 0 && m_run != len_tab[m_prev]) begin
          bad = 1; code = 2'b11;
        end
      end else begin
        bad = 1; code = 2'b10;
      end
      if (bad) begin
        m_fault = 1; m_code = code;
      end else if (e_done && m_cycles < 255) begin
        m_cycles++;
      end
    end
    m_run  = (cur == m_prev) ? m_run + 1 : 1;
    m_prev = cur;
    e_act  = m_fault ? 4'b0000 : act_tab[cur];
    e_busy = !m_fault && cur != 0;
  endfunction

  task automatic cyc(input bit r, input int m);
    rst  = r;
    mode = 3'(m);
    @(posedge clk);
    if (r) model_reset();
    else   model_step(m);
    #1;
    if (done === 1'b1) done_seen++;
    check("actuators", {valve_on, drain_on, motor_slow, motor_fast}, e_act);
    check("busy_done_abort_err", {busy, done, abort, err}, {e_busy, e_done, e_abort, m_fault});
    check("err_code", err_code, m_code);
    check("cycles", cycles, m_cycles);
  endtask

  task automatic legal_cycle();
    cyc(0, 0);
    repeat (FL) cyc(0, 1);
    repeat (RL) cyc(0, 2);
    repeat (WL) cyc(0, 3);
    repeat (SL) cyc(0, 4);
    cyc(0, 0);
  endtask

  initial begin
`ifdef WASH_SUP_DURATION_CHK_EN
    dur_en = 1;
`else
    dur_en = 0;
`endif
    model_reset();
    rst  = 1'b1;
    mode = 3'd0;

    cyc(1, 5);
    cyc(1, 0);

    // Complete legal cycle
    done_seen = 0;
    legal_cycle();
    check("legal_cycles_eq1", cycles, 1);
    check("legal_done_once", done_seen, 1);
    check("legal_no_err", err, 0);

    // Illegal code during wash, then a skip must not overwrite the code
    cyc(0, 0);
    repeat (FL) cyc(0, 1);
    repeat (RL) cyc(0, 2);
    repeat (3) cyc(0, 3);
    cyc(0, 6);
    check("illegal_code", err_code, 2'b01);
    check("illegal_act_off", {valve_on, drain_on, motor_slow, motor_fast}, 0);
    cyc(0, 1);
    cyc(0, 4);
    check("first_fault_held", err_code, 2'b01);
    cyc(1, 0);

    // Skip fill->wash, reset mid-phase, then a clean cycle
    cyc(0, 0);
    repeat (2) cyc(0, 1);
    cyc(0, 3);
    check("skip_trans", err_code, 2'b10);
    cyc(0, 3);
    cyc(1, 2);
    check("rst_clears_err", {err, err_code}, 0);
    legal_cycle();
    check("post_rst_cycle", cycles, 1);

    // Early return from rinse
    cyc(0, 0);
    repeat (FL) cyc(0, 1);
    repeat (3) cyc(0, 2);
    cyc(0, 0);
    check("abort_pulse", abort, 1);
    check("abort_busy_low", busy, 0);
    check("abort_cycles_same", cycles, 1);
    cyc(0, 0);
    check("abort_one_cycle", abort, 0);

    // Fill held one cycle too long
    cyc(0, 0);
    repeat (5) cyc(0, 1);
    check("long_fill_err", err, dur_en);
    cyc(1, 0);

    // Saturation of the completed-cycle counter
    done_seen = 0;
    repeat (256) legal_cycle();
    check("cycles_saturate", cycles, 255);
    check("done_each_cycle", done_seen, 256);
    cyc(1, 0);

    // Random walk: mostly legal progress with dwell jitter and occasional faults/resets
    begin
      int cur_m = 0;
      repeat (3000) begin
        int r = $urandom_range(0, 99);
        if (r < 3) begin
          legal_cycle();
          cur_m = 0;
        end else if (r < 58) begin
          cyc(0, cur_m);
        end else if (r < 80) begin
          cur_m = (cur_m <= 4) ? nxt_tab[cur_m] : 0;
          cyc(0, cur_m);
        end else if (r < 89) begin
          cur_m = 0;
          cyc(0, 0);
        end else if (r < 96) begin
          cur_m = $urandom_range(0, 7);
          cyc(0, cur_m);
        end else begin
          cur_m = 0;
          cyc(1, $urandom_range(0, 7));
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wash_supervisor.md
WASH_SUPERVISOR -- requirements
Module: wash_supervisor

Interface
REQ-001 Parameter FILL_LEN, default 4, required fill phase length in clock cycles.
REQ-002 Parameter RINSE_LEN, default 6, required rinse phase length in cycles.
REQ-003 Parameter WASH_LEN, default 11, required wash phase length in cycles.
REQ-004 Parameter SPIN_LEN, default 9, required spin phase length in cycles.
REQ-005 Port clk  input  1  single clock, rising-edge.
REQ-006 Port rst  input  1  reset, synchronous, active-high.
REQ-007 Port mode  input  3  controller phase code: 0 standby, 1 fill, 2 rinse, 3 wash, 4 spin; 5-7 illegal.
REQ-008 Port valve_on  output  1  water inlet valve drive.
REQ-009 Port drain_on  output  1  drain pump drive.
REQ-010 Port motor_slow  output  1  drum motor, agitate speed.
REQ-011 Port motor_fast  output  1  drum motor, spin speed.
REQ-012 Port busy  output  1  high while a phase other than standby is tracked.
REQ-013 Port done  output  1  one-cycle pulse on legal cycle completion.
REQ-014 Port abort  output  1  one-cycle pulse on early return to standby.
REQ-015 Port err  output  1  sticky fault flag.
REQ-016 Port err_code  output  2  00 none, 01 illegal code, 10 illegal transition, 11 duration mismatch.
REQ-017 Port cycles  output  8  count of completed cycles, saturating.

Function
REQ-018 mode SHALL be sampled into mode_q every cycle; all outputs SHALL be registered, one cycle latency from mode to outputs.
REQ-019 Actuator decode SHALL be: fill->valve_on; rinse->valve_on+motor_slow; wash->motor_slow; spin->drain_on+motor_fast; standby or illegal->all off.
REQ-020 Tracker FSM states SHALL be IDLE, RUN, FAULT; IDLE->RUN on standby->fill; RUN->IDLE on any->standby; any->FAULT on error.
REQ-021 Legal transitions SHALL be standby->fill->rinse->wash->spin->standby, any non-standby->standby, and unchanged mode.
REQ-022 mode in 5-7 SHALL set err, err_code=01, enter FAULT.
REQ-023 Any other change (skip, backward, standby->non-fill) SHALL set err, err_code=10, enter FAULT.
REQ-024 A 4-bit phase counter SHALL count consecutive cycles in the current phase, clear on each change, saturate at 15.
REQ-025 spin->standby SHALL pulse done and increment cycles (hold at 255); fill/rinse/wash->standby SHALL pulse abort.
REQ-026 In FAULT, all actuators SHALL be off, busy low, done/abort suppressed; exit only via rst.
REQ-027 err_code SHALL hold the first fault; later faults SHALL NOT overwrite it.
REQ-028 When an error and done/abort coincide in one cycle, error SHALL take priority and the pulse SHALL be suppressed.

Reset
REQ-029 On rst: mode_q=0, FSM=IDLE, counter=0, all outputs 0 including err, err_code, cycles.
REQ-030 rst mid-phase SHALL force all actuators off on the next edge; the first post-reset transition is judged from standby.

Configuration
REQ-031 Macro WASH_SUP_DURATION_CHK_EN SHALL compile in duration checking.
REQ-032 With it: exit from phase X to the next legal phase with count != X_LEN, or count reaching X_LEN+1 while still in X, SHALL set err_code=11 and enter FAULT; spin->standby with short spin SHALL pulse abort, not done.
REQ-033 Without it: no duration check; spin->standby always yields done; err_code 11 never produced.

Structure
REQ-034 Package wash_pkg SHALL hold the mode codes, err_code values, tracker state enum and default lengths, shared with the controller.
REQ-035 Sub-module wash_act_decode SHALL implement the combinational mode-to-actuator decode of REQ-019.

Verification
REQ-036 Legal cycle 0,fill x4,rinse x6,wash x11,spin x9,0 -> actuators per phase one cycle late, done pulse once, cycles=1, err=0.
REQ-037 mode=6 during wash -> err=1, err_code=01, all actuators 0 next cycle; later skip leaves err_code=01.
REQ-038 fill->wash -> err_code=10, FAULT; rst -> all outputs 0, new legal cycle completes normally.
REQ-039 rinse x3 then 0 -> abort pulse, cycles unchanged, busy low, err=0.
REQ-040 With macro, fill x5 -> err_code=11 on 5th fill cycle; without macro same stimulus -> no error.
REQ-041 256 legal cycles -> cycles saturates at 255, done still pulses each cycle.
